// File: rtl/vga_pkg.sv
// Shared definitions for the register-file VGA text display:
// default 640x480 timing, colour type and constants, region codes,
// and small helpers for frame totals and the status title colour.
package vga_pkg;

    localparam int H_SYNC_DEF        = 96;
    localparam int H_BACK_DEF        = 48;
    localparam int H_DISP_DEF        = 640;
    localparam int H_FRONT_DEF       = 16;
    localparam int V_SYNC_DEF        = 2;
    localparam int V_BACK_DEF        = 29;
    localparam int V_DISP_DEF        = 480;
    localparam int V_FRONT_DEF       = 10;
    localparam int NUM_REGS_DEF      = 8;
    localparam int REG_W_DEF         = 32;
    localparam int TITLE_H_DEF       = 125;
    localparam int TEXT_X0_DEF       = 238;
    localparam int TEXT_Y0_DEF       = 170;
    localparam int HILITE_FRAMES_DEF = 4;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t BLUE   = 12'h00F;
    localparam rgb_t YELLOW = 12'hFF0;
    localparam rgb_t RED    = 12'hF00;
    localparam rgb_t GREY   = 12'h888;
    localparam rgb_t GREEN  = 12'h0F0;
    localparam rgb_t WHITE  = 12'hFFF;
    localparam rgb_t BLACK  = 12'h000;

    // Screen region of a pixel, decided in the first pipeline stage
    typedef enum logic [1:0] {
        RGN_BLANK = 2'd0,
        RGN_TITLE = 2'd1,
        RGN_TEXT  = 2'd2,
        RGN_BG    = 2'd3
    } region_t;

    function automatic int h_total(input int sync, input int back, input int disp, input int front);
        return sync + back + disp + front;
    endfunction

    function automatic int v_total(input int sync, input int back, input int disp, input int front);
        return sync + back + disp + front;
    endfunction

    // Title band colour follows the controller state
    function automatic rgb_t title_colour(input logic [2:0] q);
        rgb_t c;
        case (q)
            3'd0, 3'd1: c = BLUE;
            3'd2:       c = YELLOW;
            3'd3, 3'd4: c = RED;
            default:    c = GREY;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_hex_glyph.sv
// Synchronous 8x16 font ROM holding the hex digits 0-F.
// One glyph row comes out one clock after nibble/row are presented,
// which makes it part of the first display pipeline stage.
module vga_hex_glyph (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] nibble,
    input  logic [3:0] row,
    output logic [7:0] bits
);

    // Row 0 of a glyph is the top byte; bit 7 of a row is its leftmost pixel
    function automatic logic [7:0] font_row(input logic [3:0] n, input logic [3:0] r);
        logic [127:0] g;
        case (n)
            4'h0:    g = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
            4'h1:    g = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
            4'h2:    g = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
            4'h3:    g = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
            4'h4:    g = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
            4'h5:    g = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
            4'h6:    g = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
            4'h7:    g = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
            4'h8:    g = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
            4'h9:    g = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
            4'hA:    g = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
            4'hB:    g = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
            4'hC:    g = 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000;
            4'hD:    g = 128'h0000_F86C_6666_6666_6666_6CF8_0000_0000;
            4'hE:    g = 128'h0000_FE66_6268_7868_6062_66FE_0000_0000;
            4'hF:    g = 128'h0000_FE66_6268_7868_6060_60F0_0000_0000;
            default: g = 128'h0;
        endcase
        return g[127 - 8 * int'(r) -: 8];
    endfunction

    // Registered ROM read
    always_ff @(posedge clk) begin
        if (rst) begin
            bits <= 8'h00;
        end else begin
            bits <= font_row(nibble, row);
        end
    end

endmodule

// File: rtl/vga_regfile_display.sv
// VGA text engine showing NUM_REGS registers as hex rows under a
// status title band. Two-stage pipeline from counters to pins:
// stage 1 decodes the region and fetches a glyph row, stage 2 picks
// the pixel bit and drives the R/G/B registers; syncs and frame_tick
// travel through the same two stages. The register file is
// snapshotted at the first pixel slot of each frame.
// Build option: define REG_HILITE_EN to draw recently changed
// registers in red for HILITE_FRAMES frames.
module vga_regfile_display
    import vga_pkg::*;
#(
    parameter int H_SYNC        = H_SYNC_DEF,
    parameter int H_BACK        = H_BACK_DEF,
    parameter int H_DISP        = H_DISP_DEF,
    parameter int H_FRONT       = H_FRONT_DEF,
    parameter int V_SYNC        = V_SYNC_DEF,
    parameter int V_BACK        = V_BACK_DEF,
    parameter int V_DISP        = V_DISP_DEF,
    parameter int V_FRONT       = V_FRONT_DEF,
    parameter int NUM_REGS      = NUM_REGS_DEF,
    parameter int REG_W         = REG_W_DEF,
    parameter int TITLE_H       = TITLE_H_DEF,
    parameter int TEXT_X0       = TEXT_X0_DEF,
    parameter int TEXT_Y0       = TEXT_Y0_DEF,
    parameter int HILITE_FRAMES = HILITE_FRAMES_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [2:0]                Q,
    input  logic [NUM_REGS*REG_W-1:0] regfiles,
    output logic [3:0]                R,
    output logic [3:0]                G,
    output logic [3:0]                B,
    output logic                      HS,
    output logic                      VS,
    output logic                      frame_tick
);

    localparam int H_TOTAL = h_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
    localparam int V_TOTAL = v_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int H_VIS0  = H_SYNC + H_BACK;
    localparam int V_VIS0  = V_SYNC + V_BACK;
    localparam int NIB     = REG_W / 4;
    localparam int TEXT_W  = NIB * 16;
    localparam int TEXT_H  = NUM_REGS * 32;

    logic [HW-1:0]    hcnt;
    logic [VW-1:0]    vcnt;
    logic [REG_W-1:0] snap [NUM_REGS];

    int               x_s, y_s, dx_s, dy_s;
    int               row_idx_s, col_idx_s;
    logic             frame_start_s, hs_raw_s, vs_raw_s, in_vis_s, in_text_s;
    logic [REG_W-1:0] reg_word_s;
    logic [3:0]       nibble_s, glyph_row_s;
    logic [2:0]       bitcol_s;
    region_t          region_s;
    logic             hl_s;

    region_t          region_r;
    logic [2:0]       bitcol_r;
    rgb_t             title_r;
    logic             hl_r, hs_r, vs_r, tick_r;
    logic [7:0]       glyph_bits;
    logic             bit_on_s;
    rgb_t             px_s;

    // Pixel and line counters, both wrapping at their totals
    always_ff @(posedge CLK) begin
        if (RST) begin
            hcnt <= HW'(0);
            vcnt <= VW'(0);
        end else if (hcnt == HW'(H_TOTAL - 1)) begin
            hcnt <= HW'(0);
            if (vcnt == VW'(V_TOTAL - 1)) begin
                vcnt <= VW'(0);
            end else begin
                vcnt <= vcnt + VW'(1);
            end
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    // Capture the whole register file once per frame so a frame never tears
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) snap[i] <= '0;
        end else if (frame_start_s) begin
            for (int i = 0; i < NUM_REGS; i++) snap[i] <= regfiles[i*REG_W +: REG_W];
        end else begin
            for (int i = 0; i < NUM_REGS; i++) snap[i] <= snap[i];
        end
    end

    // Stage-1 decode: syncs, region, text cell and glyph coordinates
    always_comb begin
        x_s           = int'(hcnt) - H_VIS0;
        y_s           = int'(vcnt) - V_VIS0;
        dx_s          = x_s - TEXT_X0;
        dy_s          = y_s - TEXT_Y0;
        frame_start_s = (hcnt == HW'(0)) && (vcnt == VW'(0));
        hs_raw_s      = (int'(hcnt) >= H_SYNC);
        vs_raw_s      = (int'(vcnt) >= V_SYNC);
        in_vis_s      = (x_s >= 0) && (x_s < H_DISP) && (y_s >= 0) && (y_s < V_DISP);
        in_text_s     = (dx_s >= 0) && (dx_s < TEXT_W) && (dy_s >= 0) && (dy_s < TEXT_H);
        // Indices are forced to 0 outside the grid so no read leaves the register file
        row_idx_s     = in_text_s ? (dy_s >>> 5) : 0;
        col_idx_s     = in_text_s ? (dx_s >>> 4) : 0;
        reg_word_s    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_word_s = reg_word_s | (snap[i] & {REG_W{(i == row_idx_s)}});
        end
        nibble_s      = 4'(reg_word_s >> (4 * (NIB - 1 - col_idx_s)));
        glyph_row_s   = 4'(dy_s >>> 1);
        bitcol_s      = 3'(dx_s >>> 1);
        if (!in_vis_s) begin
            region_s = RGN_BLANK;
        end else if (y_s < TITLE_H) begin
            region_s = RGN_TITLE;
        end else if (in_text_s) begin
            region_s = RGN_TEXT;
        end else begin
            region_s = RGN_BG;
        end
    end

`ifdef REG_HILITE_EN
    localparam int CW = (HILITE_FRAMES > 0) ? $clog2(HILITE_FRAMES + 1) : 1;
    logic [CW-1:0] hl_cnt [NUM_REGS];

    // Reload a register's countdown when its snapshot changes, else count down per frame
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) hl_cnt[i] <= CW'(0);
        end else if (frame_start_s) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (regfiles[i*REG_W +: REG_W] != snap[i]) begin
                    hl_cnt[i] <= CW'(HILITE_FRAMES);
                end else if (hl_cnt[i] != CW'(0)) begin
                    hl_cnt[i] <= hl_cnt[i] - CW'(1);
                end else begin
                    hl_cnt[i] <= hl_cnt[i];
                end
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) hl_cnt[i] <= hl_cnt[i];
        end
    end

    // Flag the text row whose register is still counting down
    always_comb begin
        hl_s = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            hl_s = hl_s | (in_text_s && (i == row_idx_s) && (hl_cnt[i] != CW'(0)));
        end
    end
`else
    // Highlighting is compiled out, so HILITE_FRAMES has no effect here
    always_comb begin
        hl_s = (HILITE_FRAMES < 0);
    end
`endif

    vga_hex_glyph u_glyph (
        .clk    (CLK),
        .rst    (RST),
        .nibble (nibble_s),
        .row    (glyph_row_s),
        .bits   (glyph_bits)
    );

    // Stage-1 registers, aligned with the glyph ROM output
    always_ff @(posedge CLK) begin
        if (RST) begin
            region_r <= RGN_BLANK;
            bitcol_r <= 3'd0;
            title_r  <= BLACK;
            hl_r     <= 1'b0;
            hs_r     <= 1'b1;
            vs_r     <= 1'b1;
            tick_r   <= 1'b0;
        end else begin
            region_r <= region_s;
            bitcol_r <= bitcol_s;
            title_r  <= title_colour(Q);
            hl_r     <= hl_s;
            hs_r     <= hs_raw_s;
            vs_r     <= vs_raw_s;
            tick_r   <= frame_start_s;
        end
    end

    // Stage-2 colour selection for the current pixel
    always_comb begin
        bit_on_s = glyph_bits[3'd7 - bitcol_r];
        px_s     = BLACK;
        case (region_r)
            RGN_TITLE: px_s = title_r;
            RGN_TEXT:  px_s = bit_on_s ? (hl_r ? RED : GREEN) : WHITE;
            RGN_BG:    px_s = WHITE;
            default:   px_s = BLACK;
        endcase
    end

    // Stage-2 output registers driving the connector
    always_ff @(posedge CLK) begin
        if (RST) begin
            R          <= 4'd0;
            G          <= 4'd0;
            B          <= 4'd0;
            HS         <= 1'b1;
            VS         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            R          <= px_s.r;
            G          <= px_s.g;
            B          <= px_s.b;
            HS         <= hs_r;
            VS         <= vs_r;
            frame_tick <= tick_r;
        end
    end

endmodule

// File: tb/tb_vga_regfile_display.sv
// Directed bench for vga_regfile_display on a shrunken screen
// (48x142 total, 40x136 visible, 4 regs of 8 bits) so several frames
// fit in a short run. Pixel (x,y) of frame f leaves the DUT at
// position f*FT + (y+VOFF)*HT + x+HOFF + 2 after reset release.
module tb_vga_regfile_display;

    localparam int HT   = 48;
    localparam int VT   = 142;
    localparam int FT   = HT * VT;
    localparam int HOFF = 6;
    localparam int VOFF = 4;

    localparam logic [11:0] C_BLACK = 12'h000;
    localparam logic [11:0] C_BLUE  = 12'h00F;
    localparam logic [11:0] C_YEL   = 12'hFF0;
    localparam logic [11:0] C_RED   = 12'hF00;
    localparam logic [11:0] C_GREY  = 12'h888;
    localparam logic [11:0] C_GREEN = 12'h0F0;
    localparam logic [11:0] C_WHITE = 12'hFFF;
`ifdef REG_HILITE_EN
    localparam logic [11:0] C_HOT   = 12'hF00;
`else
    localparam logic [11:0] C_HOT   = 12'h0F0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  Q;
    logic [31:0] regfiles;
    logic [3:0]  R, G, B;
    logic        HS, VS, frame_tick;

    int checks;
    int errors;
    int pos;

    vga_regfile_display #(
        .H_SYNC(4), .H_BACK(2), .H_DISP(40), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_DISP(136), .V_FRONT(2),
        .NUM_REGS(4), .REG_W(8), .TITLE_H(4), .TEXT_X0(4), .TEXT_Y0(6),
        .HILITE_FRAMES(2)
    ) dut (
        .CLK(CLK), .RST(RST), .Q(Q), .regfiles(regfiles),
        .R(R), .G(G), .B(B), .HS(HS), .VS(VS), .frame_tick(frame_tick)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the given number of clocks after reset release, then sample 1ns later
    task automatic adv_to(input int k);
        repeat (k - pos) @(posedge CLK);
        pos = k;
        #1;
    endtask

    function automatic int pix(input int x, input int y, input int f);
        return f * FT + (y + VOFF) * HT + x + HOFF + 2;
    endfunction

    task automatic check_px(input string tag, input int x, input int y, input int f, input logic [11:0] exp);
        adv_to(pix(x, y, f));
        check(tag, {R, G, B}, exp);
    endtask

    task automatic sync_checks();
        adv_to(1);
        check("hs_before_pipe", {11'd0, HS}, 12'd1);
        adv_to(2);
        check("hs_lo_first", {11'd0, HS}, 12'd0);
        check("vs_lo_first", {11'd0, VS}, 12'd0);
        check("tick_on", {11'd0, frame_tick}, 12'd1);
        check("rgb_hsync_blank", {R, G, B}, C_BLACK);
        adv_to(3);
        check("tick_off", {11'd0, frame_tick}, 12'd0);
        adv_to(5);
        check("hs_lo_last", {11'd0, HS}, 12'd0);
        adv_to(6);
        check("hs_hi", {11'd0, HS}, 12'd1);
        adv_to(2 * HT + 1);
        check("vs_lo_last", {11'd0, VS}, 12'd0);
        adv_to(2 * HT + 2);
        check("vs_hi", {11'd0, VS}, 12'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at pos %0d", pos);
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        pos      = 0;
        Q        = 3'd0;
        regfiles = {8'h00, 8'h00, 8'h00, 8'h0F};

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_rgb", {R, G, B}, C_BLACK);
        check("rst_hs", {11'd0, HS}, 12'd1);
        check("rst_vs", {11'd0, VS}, 12'd1);
        check("rst_tick", {11'd0, frame_tick}, 12'd0);
        RST = 1'b0;
        pos = 0;

        sync_checks();

        // Title band colour by controller state
        check_px("title_q0", 10, 1, 0, C_BLUE);
        Q = 3'd3;
        check_px("title_q3", 10, 2, 0, C_RED);
        Q = 3'd6;
        check_px("title_q6", 10, 3, 0, C_GREY);
        Q = 3'd2;
        check_px("title_q2", 20, 3, 0, C_YEL);
        Q = 3'd0;

        // Background band and reg0 = 0F glyph pixels
        check_px("bg_below_title", 10, 4, 0, C_WHITE);
        check_px("F_row0_blank", 22, 6, 0, C_WHITE);
        check_px("0_row2_col0", 4, 10, 0, C_WHITE);
        check_px("0_row2_col1", 6, 10, 0, C_HOT);
        check_px("F_row2_col0", 20, 10, 0, C_HOT);
        check_px("F_row2_col7", 34, 10, 0, C_WHITE);
        check_px("right_of_text", 37, 10, 0, C_WHITE);
        check_px("F_row3_col0", 20, 12, 0, C_WHITE);
        check_px("F_row3_col1", 22, 12, 0, C_HOT);
        adv_to(20 * HT + 47 + 2);
        check("hfront_blank", {R, G, B}, C_BLACK);

        // Mid-frame change of reg2 must wait for the next frame
        regfiles[23:16] = 8'hF0;
        check_px("reg2_old_col0", 4, 74, 0, C_WHITE);
        check_px("reg2_old_col1", 6, 74, 0, C_GREEN);
        check_px("bg_below_text", 10, 135, 0, C_WHITE);
        adv_to(141 * HT + 20 + 2);
        check("vfront_blank", {R, G, B}, C_BLACK);
        adv_to(FT + 2);
        check("tick_frame1", {11'd0, frame_tick}, 12'd1);
        check_px("reg2_new_col0", 4, 74, 1, C_HOT);

        // reg3 changes once; colour of its set pixels over following frames
        check_px("reg3_old", 4, 106, 1, C_WHITE);
        regfiles[31:24] = 8'hF0;
        check_px("reg3_f2", 4, 106, 2, C_HOT);
        check_px("reg3_f3", 4, 106, 3, C_HOT);
        check_px("reg3_f4", 4, 106, 4, C_GREEN);

        // Reset asserted mid-line
        check_px("pre_reset_px", 37, 120, 4, C_WHITE);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("midrst_rgb", {R, G, B}, C_BLACK);
        check("midrst_hs", {11'd0, HS}, 12'd1);
        check("midrst_vs", {11'd0, VS}, 12'd1);
        RST = 1'b0;
        pos = 0;
        sync_checks();
        check_px("title_after_rst", 10, 1, 0, C_BLUE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
